// File: rtl/vga_image_processing.sv
// 640x480 VGA timing generator feeding a streaming 12x12 tile averager.
// Each completed tile yields floor(sum/144) as a 4-bit brightness for glyph selection.
module vga_image_processing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int TILE   = 12
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [3:0]  doutb,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column,
  output logic        pix_num,
  output logic [3:0]  average,
  output logic        average_valid
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int N_TC  = H_VIS / TILE;
  localparam int IW    = $clog2(N_TC);

  localparam logic [11:0] H_LAST  = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOT - 1);
  localparam logic [11:0] H_VIS_L = 12'(H_VIS);
  localparam logic [11:0] V_VIS_L = 12'(V_VIS);
  localparam logic [11:0] HS_BEG  = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_VIS + V_FP + V_SYNC);
  localparam logic [3:0]  T_LAST  = 4'(TILE - 1);
  localparam logic [6:0]  N_TC_L  = 7'(N_TC);

  // Raster counters carry their own mod-TILE and tile-index companions so no divider is needed.
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [3:0]  hm_q, hm_d, vm_q, vm_d;
  logic [6:0]  ht_q, ht_d;

  logic [11:0] col_q, row_q;
  logic        von_q, hs_q, vs_q, pn_q;
  logic [3:0]  cm_q, rm_q;
  logic [6:0]  ct_q;

  always_comb begin
    h_d  = h_q + 12'd1;
    hm_d = hm_q + 4'd1;
    ht_d = ht_q;
    v_d  = v_q;
    vm_d = vm_q;
    if (hm_q == T_LAST) begin
      hm_d = 4'd0;
      ht_d = ht_q + 7'd1;
    end
    if (h_q == H_LAST) begin
      h_d  = 12'd0;
      hm_d = 4'd0;
      ht_d = 7'd0;
      v_d  = v_q + 12'd1;
      vm_d = (vm_q == T_LAST) ? 4'd0 : vm_q + 4'd1;
      if (v_q == V_LAST) begin
        v_d  = 12'd0;
        vm_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      h_q   <= 12'd0;
      v_q   <= 12'd0;
      hm_q  <= 4'd0;
      vm_q  <= 4'd0;
      ht_q  <= 7'd0;
      col_q <= 12'd0;
      row_q <= 12'd0;
      von_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      pn_q  <= 1'b0;
      cm_q  <= 4'd0;
      rm_q  <= 4'd0;
      ct_q  <= 7'd0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hm_q  <= hm_d;
      vm_q  <= vm_d;
      ht_q  <= ht_d;
      col_q <= h_q;
      row_q <= v_q;
      von_q <= (h_q < H_VIS_L) && (v_q < V_VIS_L);
      hs_q  <= !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_q  <= !((v_q >= VS_BEG) && (v_q < VS_END));
      pn_q  <= (h_q == 12'd0) && (v_q == 12'd0);
      cm_q  <= hm_q;
      rm_q  <= vm_q;
      ct_q  <= ht_q;
    end
  end

  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign video_on     = von_q;
  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign pix_num      = pn_q;

  logic [11:0]   acc_q [N_TC];
  logic [IW-1:0] idx;
  logic [11:0]   sum;
  logic [3:0]    avg_d, avg_q;
  logic          sample, tile_last, vld_q;

  // The partial tile at the right edge has no accumulator and is skipped.
  assign idx       = ct_q[IW-1:0];
  assign sample    = von_q && (ct_q < N_TC_L);
  assign tile_last = (cm_q == T_LAST) && (rm_q == T_LAST);
  assign sum       = acc_q[idx] + {8'd0, doutb};

  // Threshold ladder gives an exact floor(sum/144) over the whole 0..2160 range.
  always_comb begin
    avg_d = 4'd0;
    for (int k = 1; k <= 15; k++) begin
      if (sum >= 12'(TILE * TILE * k)) avg_d = 4'(k);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      for (int i = 0; i < N_TC; i++) acc_q[i] <= 12'd0;
      avg_q <= 4'd0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (pn_q) begin
        for (int i = 0; i < N_TC; i++) acc_q[i] <= 12'd0;
      end
      if (sample) begin
        if (tile_last) begin
          acc_q[idx] <= 12'd0;
          avg_q      <= avg_d;
          vld_q      <= 1'b1;
        end else begin
          acc_q[idx] <= sum;
        end
      end
    end
  end

  assign average       = avg_q;
  assign average_valid = vld_q;

endmodule

// File: tb/tb_vga_image_processing.sv
// Directed bench for vga_image_processing with a shortened vertical frame (30 lines)
// so several full frames fit in a short run; horizontal timing is the real 800-clock line.
module tb_vga_image_processing;

  localparam int VV = 24, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = 800, VT = VV + VFP + VSY + VBP;
  localparam int NTC = 53;
  localparam logic [32:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 4'd0, 1'b0};

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  doutb = 4'd0;
  logic        horiz_sync, vert_sync, video_on, pix_num, average_valid;
  logic [11:0] pixel_row, pixel_column;
  logic [3:0]  average;

  vga_image_processing #(
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clock(clock), .rst(rst), .doutb(doutb),
    .horiz_sync(horiz_sync), .vert_sync(vert_sync), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column), .pix_num(pix_num),
    .average(average), .average_valid(average_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  int mh, mv, sel;
  int cyc, last_pn, pn_gap;
  int pulses, vs_low, hs_low, von_cnt;
  logic [3:0] exp_avg;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (row %0d col %0d)", tag, obs, exp, mv, mh);
    end
  endtask

  function automatic logic [3:0] pat(input int r, input int c);
    int tr, tc, lr, lc;
    tr = r / 12; tc = c / 12; lr = r % 12; lc = c % 12;
    if (sel == 1) return 4'd6;
    if (sel == 2) return 4'd15;
    if (tr == 0) begin
      case (tc)
        0: return 4'd9;
        1: return 4'd3;
        2: return 4'((lr + lc) % 2);
        3: return ((lr + lc) % 2 == 1) ? 4'd15 : 4'd0;
        4: return (lr == 0 && lc == 0) ? 4'd14 : 4'd15;
        5: return 4'd1;
        6: return (lr == 5 && lc == 5) ? 4'd0 : 4'd1;
        default: return 4'd15;
      endcase
    end
    if (tc == 0) return 4'd0;
    if (tc == 1) return 4'd14;
    return 4'd15;
  endfunction

  // Hand-computed averages for the mixed pattern: 144*9, 144*3, 72, 1080, 2159, 144, 143, 2160.
  function automatic logic [3:0] tile_exp(input int tr, input int tc);
    if (tr == 0) begin
      case (tc)
        0: return 4'd9;
        1: return 4'd3;
        2: return 4'd0;
        3: return 4'd7;
        4: return 4'd14;
        5: return 4'd1;
        6: return 4'd0;
        default: return 4'd15;
      endcase
    end
    if (tc == 0) return 4'd0;
    if (tc == 1) return 4'd14;
    return 4'd15;
  endfunction

  function automatic logic [32:0] exp_vec(input int h, input int v, input logic [3:0] a, input logic vld);
    logic von, hs, vs, pn;
    von = (h < 640) && (v < VV);
    hs  = !((h >= 656) && (h < 752));
    vs  = !((v >= VV + VFP) && (v < VV + VFP + VSY));
    pn  = (h == 0) && (v == 0);
    return {von, hs, vs, pn, 12'(v), 12'(h), a, vld};
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b0;
    doutb = 4'd0;
    repeat (n) begin
      @(posedge clock); #1;
      chk("reset_state", {video_on, horiz_sync, vert_sync, pix_num, pixel_row, pixel_column,
                          average, average_valid}, RST_VEC);
    end
    rst = 1'b1;
    mh = HT - 1;
    mv = VT - 1;
    exp_avg = 4'd0;
    exp_q.delete();
  endtask

  task automatic run(input int n);
    logic ev;
    repeat (n) begin
      ev = (mv < VV) && (mh < 636) && (mv % 12 == 11) && (mh % 12 == 11);
      @(posedge clock); #1;
      cyc++;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
      if (ev) begin
        chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) exp_avg = exp_q.pop_front();
        chk("tile_avg", 64'(average), 64'(exp_avg));
      end
      chk("raster", {video_on, horiz_sync, vert_sync, pix_num, pixel_row, pixel_column,
                     average, average_valid}, exp_vec(mh, mv, exp_avg, ev));
      if (average_valid) pulses++;
      if (!vert_sync) vs_low++;
      if (!horiz_sync) hs_low++;
      if (video_on) von_cnt++;
      if (pix_num) begin
        pn_gap = cyc - last_pn;
        last_pn = cyc;
      end
      doutb = (mv < VV && mh < 636) ? pat(mv, mh) : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    sel = 0;
    do_reset(4);
    for (int tr = 0; tr < VV / 12; tr++)
      for (int tc = 0; tc < NTC; tc++) exp_q.push_back(tile_exp(tr, tc));
    cyc = 0; last_pn = 0; pn_gap = 0;
    pulses = 0; vs_low = 0; hs_low = 0; von_cnt = 0;

    run(1);
    chk("first_edge", {pixel_row, pixel_column, video_on, pix_num}, {12'd0, 12'd0, 1'b1, 1'b1});
    run(HT * VT - 1);
    chk("pulses_per_frame", 64'(pulses), 64'(NTC * (VV / 12)));
    chk("vsync_low_cycles", 64'(vs_low), 64'(VSY * HT));
    chk("hsync_low_cycles", 64'(hs_low), 64'(96 * VT));
    chk("video_on_cycles", 64'(von_cnt), 64'(640 * VV));
    chk("frame1_sb_drained", 64'(exp_q.size()), 64'd0);

    sel = 2;
    for (int tc = 0; tc < NTC; tc++) exp_q.push_back(4'd15);
    run(1);
    chk("frame_period", 64'(pn_gap), 64'(HT * VT));
    run(13 * HT + 300 - 1);
    chk("frame2_row0_drained", 64'(exp_q.size()), 64'd0);
    chk("frame2_last_avg", 64'(average), 64'd15);

    do_reset(3);
    sel = 1;
    for (int tc = 0; tc < NTC; tc++) exp_q.push_back(4'd6);
    run(12 * HT);
    chk("restart_sb_drained", 64'(exp_q.size()), 64'd0);
    chk("restart_avg", 64'(average), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
